lsb_queue: RTL and testbench

- In-order load/store buffer between decoder issue and the memory controller.
- Holds memory ops until address and data operands resolve.
- Loads execute speculatively at queue head. Stores execute only after the ROB commits them.
- Load results go back to the ROB and reservation stations as the lsb_config/lsb_rob_entry/lsb_value broadcast. Committed-store completion is consumed from commit_lsb_config/commit_lsb_rob.

---
 rtl/lsb_queue.sv | 170 +++++++++++++++++
 tb/tb_lsb_queue.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_queue.sv
// lsb_queue: in-order load/store buffer feeding the memory controller.
// Optional LSB_PERF_EN adds perf_load_cnt/perf_store_cnt completion counters.
module lsb_queue #(
  parameter int LSB_SIZE_LOG = 3,
  parameter int ROB_TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue_valid,
  input  logic                 issue_is_store,
  input  logic [2:0]           issue_funct3,
  input  logic [ROB_TAG_W-1:0] issue_rob,
  input  logic [31:0]          issue_imm,
  input  logic                 issue_rs1_rdy,
  input  logic [31:0]          issue_rs1_val,
  input  logic [ROB_TAG_W-1:0] issue_rs1_q,
  input  logic                 issue_rs2_rdy,
  input  logic [31:0]          issue_rs2_val,
  input  logic [ROB_TAG_W-1:0] issue_rs2_q,
  output logic                 lsb_full,
  input  logic                 alu_config,
  input  logic [ROB_TAG_W-1:0] alu_rob_entry,
  input  logic [31:0]          alu_val,
  input  logic                 commit_lsb_config,
  input  logic [ROB_TAG_W-1:0] commit_lsb_rob,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [1:0]           mem_size,
  input  logic                 mem_done,
  input  logic [31:0]          mem_rdata,
`ifdef LSB_PERF_EN
  output logic [31:0]          perf_load_cnt,
  output logic [31:0]          perf_store_cnt,
`endif
  output logic                 lsb_config,
  output logic [ROB_TAG_W-1:0] lsb_rob_entry,
  output logic [31:0]          lsb_value
);
  localparam int N = 1 << LSB_SIZE_LOG;
  localparam int CW = LSB_SIZE_LOG + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  typedef struct packed {
    logic                 valid;
    logic                 committed;
    logic                 is_store;
    logic [2:0]           funct3;
    logic [ROB_TAG_W-1:0] rob;
    logic [31:0]          imm;
    logic                 rs1_rdy;
    logic [31:0]          rs1_val;
    logic [ROB_TAG_W-1:0] rs1_q;
    logic                 rs2_rdy;
    logic [31:0]          rs2_val;
    logic [ROB_TAG_W-1:0] rs2_q;
  } ent_t;
  ent_t q [N];
  ent_t he, ie;
  state_t state, state_nxt;
  logic [LSB_SIZE_LOG-1:0] head, tail;
  logic [CW-1:0] count, keep;
  logic push, pop, start, head_ok, head_load, bc, run;
  function automatic logic hit(input logic [ROB_TAG_W-1:0] t);
    return (alu_config && alu_rob_entry == t) || (lsb_config && lsb_rob_entry == t);
  endfunction
  function automatic logic [31:0] wake_val(input logic r, input logic [31:0] v, input logic [ROB_TAG_W-1:0] t);
    return r ? v : (alu_config && alu_rob_entry == t) ? alu_val : lsb_value;
  endfunction
  function automatic logic [31:0] ext(input logic [2:0] f, input logic [31:0] d);
    return f[1] ? d : f[0] ? {{16{d[15] & ~f[2]}}, d[15:0]} : {{24{d[7] & ~f[2]}}, d[7:0]};
  endfunction
  assign he = q[head];
  assign lsb_full = count == CW'(N);
  assign head_load = !he.is_store;
  assign head_ok = he.valid && he.rs1_rdy && (head_load || (he.rs2_rdy && he.committed));
  assign start = state == IDLE && !rollback && head_ok;
  assign pop = state != IDLE && mem_done;
  assign push = issue_valid && !lsb_full && !rollback;
  assign bc = pop && state == BUSY && head_load && !rollback;
  always_comb begin
    ie.valid = 1'b1;
    ie.committed = issue_is_store && commit_lsb_config && commit_lsb_rob == issue_rob;
    ie.is_store = issue_is_store;
    ie.funct3 = issue_funct3;
    ie.rob = issue_rob;
    ie.imm = issue_imm;
    ie.rs1_rdy = issue_rs1_rdy || hit(issue_rs1_q);
    ie.rs1_val = wake_val(issue_rs1_rdy, issue_rs1_val, issue_rs1_q);
    ie.rs1_q = issue_rs1_q;
    ie.rs2_rdy = issue_rs2_rdy || hit(issue_rs2_q);
    ie.rs2_val = wake_val(issue_rs2_rdy, issue_rs2_val, issue_rs2_q);
    ie.rs2_q = issue_rs2_q;
  end
  // Survivors of a rollback: committed stores contiguous from head, plus an in-flight load being drained.
  always_comb begin
    keep = '0;
    run = 1'b1;
    for (int i = 0; i < N; i++) begin
      run = run && q[head + LSB_SIZE_LOG'(i)].valid && q[head + LSB_SIZE_LOG'(i)].committed;
      keep = keep + CW'(run);
    end
    keep = keep + CW'(state != IDLE && !he.committed);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else if (rdy) state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (start ? BUSY : IDLE) :
                mem_done ? IDLE :
                (rollback && state == BUSY && head_load) ? DRAIN : state;
  always_comb mem_req = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      lsb_config <= 1'b0;
      lsb_rob_entry <= '0;
      lsb_value <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_size <= '0;
      for (int i = 0; i < N; i++) q[i] <= '0;
    end else if (rdy) begin
      lsb_config <= bc;
      if (bc) begin
        lsb_rob_entry <= he.rob;
        lsb_value <= ext(he.funct3, mem_rdata);
      end
      if (start) begin
        mem_we <= he.is_store;
        mem_addr <= he.rs1_val + he.imm;
        mem_wdata <= he.rs2_val;
        mem_size <= he.funct3[1:0];
      end
      for (int i = 0; i < N; i++) begin
        q[i].rs1_rdy <= q[i].rs1_rdy || hit(q[i].rs1_q);
        q[i].rs1_val <= wake_val(q[i].rs1_rdy, q[i].rs1_val, q[i].rs1_q);
        q[i].rs2_rdy <= q[i].rs2_rdy || hit(q[i].rs2_q);
        q[i].rs2_val <= wake_val(q[i].rs2_rdy, q[i].rs2_val, q[i].rs2_q);
        if (!rollback && commit_lsb_config && q[i].valid && q[i].is_store && q[i].rob == commit_lsb_rob)
          q[i].committed <= 1'b1;
        if (rollback && !(q[i].committed || (state != IDLE && LSB_SIZE_LOG'(i) == head)))
          q[i].valid <= 1'b0;
      end
      if (pop) begin
        q[head].valid <= 1'b0;
        q[head].committed <= 1'b0;
      end
      if (push) q[tail] <= ie;
      head <= head + LSB_SIZE_LOG'(pop);
      tail <= rollback ? head + keep[LSB_SIZE_LOG-1:0] : tail + LSB_SIZE_LOG'(push);
      count <= rollback ? keep - CW'(pop) : count + CW'(push) - CW'(pop);
    end
  end
`ifdef LSB_PERF_EN
  always_ff @(posedge clk)
    if (rst) begin
      perf_load_cnt <= '0;
      perf_store_cnt <= '0;
    end else if (rdy && pop && state == BUSY) begin
      if (bc) perf_load_cnt <= perf_load_cnt + 32'd1;
      if (!head_load) perf_store_cnt <= perf_store_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_lsb_queue.sv
// tb_lsb_queue: directed stimulus with a queue-based reference model checked every cycle.
module tb_lsb_queue;
  logic clk = 0, rst, rdy, rollback;
  logic issue_valid, issue_is_store, issue_rs1_rdy, issue_rs2_rdy;
  logic [2:0] issue_funct3;
  logic [3:0] issue_rob, issue_rs1_q, issue_rs2_q, alu_rob_entry, commit_lsb_rob, lsb_rob_entry;
  logic [31:0] issue_imm, issue_rs1_val, issue_rs2_val, alu_val, mem_addr, mem_wdata, mem_rdata, lsb_value;
  logic lsb_full, alu_config, commit_lsb_config, mem_req, mem_we, mem_done, lsb_config;
  logic [1:0] mem_size;
`ifdef LSB_PERF_EN
  logic [31:0] perf_load_cnt, perf_store_cnt;
`endif
  int vec = 0, err = 0;
  bit mon_on = 0;

  lsb_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue_valid(issue_valid), .issue_is_store(issue_is_store), .issue_funct3(issue_funct3),
    .issue_rob(issue_rob), .issue_imm(issue_imm),
    .issue_rs1_rdy(issue_rs1_rdy), .issue_rs1_val(issue_rs1_val), .issue_rs1_q(issue_rs1_q),
    .issue_rs2_rdy(issue_rs2_rdy), .issue_rs2_val(issue_rs2_val), .issue_rs2_q(issue_rs2_q),
    .lsb_full(lsb_full), .alu_config(alu_config), .alu_rob_entry(alu_rob_entry), .alu_val(alu_val),
    .commit_lsb_config(commit_lsb_config), .commit_lsb_rob(commit_lsb_rob),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_done(mem_done), .mem_rdata(mem_rdata),
`ifdef LSB_PERF_EN
    .perf_load_cnt(perf_load_cnt), .perf_store_cnt(perf_store_cnt),
`endif
    .lsb_config(lsb_config), .lsb_rob_entry(lsb_rob_entry), .lsb_value(lsb_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit st; bit [2:0] f3; bit [3:0] rob; bit [31:0] imm;
    bit r1; bit [31:0] v1; bit [3:0] q1;
    bit r2; bit [31:0] v2; bit [3:0] q2;
    bit com;
  } op_t;
  op_t mq[$], nq[$], n;
  bit m_busy, m_disc, m_bc, m_we, pb, full, go;
  bit [3:0] m_bc_rob, pt;
  bit [31:0] m_bc_val, m_addr, m_wdata, pv;
  bit [1:0] m_size;

  function automatic bit [31:0] ext(bit [2:0] f, bit [31:0] d);
    case (f)
      3'd0: return {{24{d[7]}}, d[7:0]};
      3'd1: return {{16{d[15]}}, d[15:0]};
      3'd4: return {24'd0, d[7:0]};
      3'd5: return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Reference model: one op list, at most one outstanding memory request.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_busy = 0; m_disc = 0; m_bc = 0; m_bc_rob = 0; m_bc_val = 0;
    end else if (rdy) begin
      pb = m_bc; pt = m_bc_rob; pv = m_bc_val;
      full = mq.size() == 8;
      go = !m_busy && !rollback && mq.size() > 0 && mq[0].r1 && (!mq[0].st || (mq[0].r2 && mq[0].com));
      for (int i = 0; i < mq.size(); i++) begin
        if (!mq[i].r1 && alu_config && alu_rob_entry == mq[i].q1) begin mq[i].r1 = 1; mq[i].v1 = alu_val; end
        else if (!mq[i].r1 && pb && pt == mq[i].q1) begin mq[i].r1 = 1; mq[i].v1 = pv; end
        if (!mq[i].r2 && alu_config && alu_rob_entry == mq[i].q2) begin mq[i].r2 = 1; mq[i].v2 = alu_val; end
        else if (!mq[i].r2 && pb && pt == mq[i].q2) begin mq[i].r2 = 1; mq[i].v2 = pv; end
      end
      m_bc = 0;
      if (m_busy && mem_done) begin
        if (!mq[0].st && !m_disc && !rollback) begin
          m_bc = 1; m_bc_rob = mq[0].rob; m_bc_val = ext(mq[0].f3, mem_rdata);
        end
        void'(mq.pop_front());
        m_busy = 0; m_disc = 0;
      end
      if (!rollback) begin
        if (issue_valid && !full) begin
          n.st = issue_is_store; n.f3 = issue_funct3; n.rob = issue_rob; n.imm = issue_imm;
          n.r1 = issue_rs1_rdy; n.v1 = issue_rs1_val; n.q1 = issue_rs1_q;
          n.r2 = issue_rs2_rdy; n.v2 = issue_rs2_val; n.q2 = issue_rs2_q; n.com = 0;
          if (!n.r1 && alu_config && alu_rob_entry == n.q1) begin n.r1 = 1; n.v1 = alu_val; end
          else if (!n.r1 && pb && pt == n.q1) begin n.r1 = 1; n.v1 = pv; end
          if (!n.r2 && alu_config && alu_rob_entry == n.q2) begin n.r2 = 1; n.v2 = alu_val; end
          else if (!n.r2 && pb && pt == n.q2) begin n.r2 = 1; n.v2 = pv; end
          mq.push_back(n);
        end
        if (commit_lsb_config)
          for (int i = 0; i < mq.size(); i++)
            if (mq[i].st && mq[i].rob == commit_lsb_rob) mq[i].com = 1;
      end else begin
        nq.delete();
        for (int i = 0; i < mq.size(); i++)
          if (mq[i].com || (i == 0 && m_busy)) nq.push_back(mq[i]);
        mq = nq;
        if (m_busy && !mq[0].st) m_disc = 1;
      end
      if (go) begin
        m_busy = 1; m_we = mq[0].st; m_addr = mq[0].v1 + mq[0].imm;
        m_size = mq[0].f3[1:0]; m_wdata = mq[0].v2;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (mon_on) begin
    chk("mem_req", 32'(mem_req), 32'(m_busy));
    chk("lsb_full", 32'(lsb_full), 32'(mq.size() == 8));
    chk("lsb_config", 32'(lsb_config), 32'(m_bc));
    if (m_bc) begin
      chk("lsb_rob_entry", 32'(lsb_rob_entry), 32'(m_bc_rob));
      chk("lsb_value", lsb_value, m_bc_val);
    end
    if (m_busy) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_size", 32'(mem_size), 32'(m_size));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(bit st, bit [2:0] f3, bit [3:0] rob, bit [31:0] imm,
                       bit r1, bit [31:0] v1, bit [3:0] q1, bit r2, bit [31:0] v2, bit [3:0] q2);
    issue_valid = 1; issue_is_store = st; issue_funct3 = f3; issue_rob = rob; issue_imm = imm;
    issue_rs1_rdy = r1; issue_rs1_val = v1; issue_rs1_q = q1;
    issue_rs2_rdy = r2; issue_rs2_val = v2; issue_rs2_q = q2;
    step();
    issue_valid = 0;
  endtask

  task automatic wait_req(string nm);
    int k = 0;
    while (!mem_req && k < 20) begin step(); k++; end
    chk(nm, 32'(mem_req), 32'd1);
  endtask

  task automatic done(bit [31:0] d);
    mem_done = 1; mem_rdata = d;
    step();
    mem_done = 0;
  endtask

  task automatic pulse_alu(bit [3:0] t, bit [31:0] v);
    alu_config = 1; alu_rob_entry = t; alu_val = v;
    step();
    alu_config = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; rdy = 1; rollback = 0; issue_valid = 0; issue_is_store = 0; issue_funct3 = 0;
    issue_rob = 0; issue_imm = 0; issue_rs1_rdy = 0; issue_rs1_val = 0; issue_rs1_q = 0;
    issue_rs2_rdy = 0; issue_rs2_val = 0; issue_rs2_q = 0; alu_config = 0; alu_rob_entry = 0;
    alu_val = 0; commit_lsb_config = 0; commit_lsb_rob = 0; mem_done = 0; mem_rdata = 0;
    step(); step();
    rst = 0; mon_on = 1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_lsb_full", 32'(lsb_full), 0);
    chk("rst_lsb_config", 32'(lsb_config), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_lsb_value", lsb_value, 0);
    // LW rob 3 from 0x1000+4
    issue(0, 3'd2, 4'd3, 32'h4, 1, 32'h1000, 0, 1, 0, 0);
    chk("lw_no_req_yet", 32'(mem_req), 0);
    wait_req("lw_req");
    chk("lw_addr", mem_addr, 32'h1004);
    chk("lw_size", 32'(mem_size), 2);
    chk("lw_we", 32'(mem_we), 0);
    done(32'hDEADBEEF);
    chk("lw_bc", 32'(lsb_config), 1);
    chk("lw_rob", 32'(lsb_rob_entry), 3);
    chk("lw_val", lsb_value, 32'hDEADBEEF);
    step();
    chk("lw_bc_pulse", 32'(lsb_config), 0);
    // LB with a stalled cycle (rdy low) while busy
    issue(0, 3'd0, 4'd4, 0, 1, 32'h10, 0, 1, 0, 0);
    wait_req("lb_req");
    rdy = 0; mem_done = 1; mem_rdata = 32'h80;
    step();
    chk("rdy_hold_req", 32'(mem_req), 1);
    chk("rdy_hold_bc", 32'(lsb_config), 0);
    rdy = 1; mem_done = 0;
    done(32'h80);
    chk("lb_val", lsb_value, 32'hFFFFFF80);
    step();
    issue(0, 3'd4, 4'd4, 0, 1, 32'h10, 0, 1, 0, 0);
    wait_req("lbu_req");
    done(32'h80);
    chk("lbu_val", lsb_value, 32'h00000080);
    step();
    issue(0, 3'd1, 4'd6, 2, 1, 32'h10, 0, 1, 0, 0);
    wait_req("lh_req");
    done(32'h8000);
    chk("lh_val", lsb_value, 32'hFFFF8000);
    step();
    // SW rob 5 waiting on tag 2, held until commit
    issue(1, 3'd2, 4'd5, 0, 1, 32'h2000, 0, 0, 0, 4'd2);
    pulse_alu(4'd2, 32'h55);
    repeat (4) step();
    chk("sw_wait_commit", 32'(mem_req), 0);
    commit_lsb_config = 1; commit_lsb_rob = 5;
    step();
    commit_lsb_config = 0;
    wait_req("sw_req");
    chk("sw_we", 32'(mem_we), 1);
    chk("sw_wdata", mem_wdata, 32'h55);
    chk("sw_addr", mem_addr, 32'h2000);
    done(0);
    chk("sw_no_bc", 32'(lsb_config), 0);
    step();
    // rollback while a committed store is in flight
    issue(1, 3'd2, 4'd1, 0, 1, 32'h3000, 0, 1, 32'hAA, 0);
    issue(0, 3'd2, 4'd2, 0, 1, 32'h3100, 0, 1, 0, 0);
    commit_lsb_config = 1; commit_lsb_rob = 1;
    step();
    commit_lsb_config = 0;
    wait_req("rb_st_req");
    chk("rb_st_we", 32'(mem_we), 1);
    rollback = 1;
    step();
    rollback = 0;
    chk("rb_st_held", 32'(mem_req), 1);
    done(0);
    chk("rb_st_no_bc", 32'(lsb_config), 0);
    repeat (4) step();
    chk("rb_load_gone", 32'(mem_req), 0);
    // rollback while a load is in flight: drained, no broadcast
    issue(0, 3'd2, 4'd6, 0, 1, 32'h4000, 0, 1, 0, 0);
    wait_req("drain_req");
    rollback = 1;
    step();
    rollback = 0;
    chk("drain_held", 32'(mem_req), 1);
    done(32'h1234);
    chk("drain_no_bc", 32'(lsb_config), 0);
    repeat (3) step();
    chk("drain_idle", 32'(mem_req), 0);
    // fill to full from a clean reset, then wrap the tail
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 8; i++) issue(0, 3'd2, 4'(i), 32'(i * 4), 0, 0, 4'd9, 1, 0, 0);
    chk("full_set", 32'(lsb_full), 1);
    issue(0, 3'd2, 4'd12, 0, 1, 32'h7000, 0, 1, 0, 0);
    chk("full_ignored_push", 32'(lsb_full), 1);
    pulse_alu(4'd9, 32'h100);
    wait_req("full_req0");
    chk("full_addr0", mem_addr, 32'h100);
    done(32'hA0);
    chk("full_clear", 32'(lsb_full), 0);
    issue(0, 3'd2, 4'd10, 32'h8, 1, 32'h5000, 0, 1, 0, 0);
    chk("full_again", 32'(lsb_full), 1);
    for (int i = 1; i < 8; i++) begin
      wait_req("full_drain");
      done(32'hC0 + 32'(i));
    end
    wait_req("wrap_req");
    chk("wrap_addr", mem_addr, 32'h5008);
    done(32'h77);
    chk("wrap_rob", 32'(lsb_rob_entry), 10);
    step();
    // reset mid-transaction, later stray mem_done ignored
    issue(0, 3'd2, 4'd7, 0, 1, 32'h6000, 0, 1, 0, 0);
    wait_req("rst_busy_req");
    rst = 1;
    step();
    rst = 0;
    chk("rstb_mem_req", 32'(mem_req), 0);
    chk("rstb_mem_addr", mem_addr, 0);
    chk("rstb_mem_size", 32'(mem_size), 0);
    chk("rstb_lsb_config", 32'(lsb_config), 0);
    done(32'h99);
    chk("rstb_stray_done", 32'(lsb_config), 0);
    step();
    chk("rstb_idle", 32'(mem_req), 0);
    mon_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
